// File: rtl/z80fi_insn_collector_if.sv
// Core-side bus for the Z80FI instruction collector: fetch/retire strobes in,
// retirement record and sticky error flags out.
interface z80fi_insn_collector_if #(
  parameter int MAX_LEN = 4
);
  logic                   insn_start;
  logic [15:0]            pc_in;
  logic                   fetch_valid;
  logic [7:0]             fetch_data;
  logic                   insn_done;
  logic [15:0]            pc_next;
  logic                   z80fi_valid;
  logic [8*MAX_LEN-1:0]   z80fi_insn;
  logic [2:0]             z80fi_insn_len;
  logic [15:0]            z80fi_pc_rdata;
  logic [15:0]            z80fi_pc_wdata;
  logic                   err_overflow;
  logic                   err_protocol;

  // Core / stimulus side
  modport master (
    output insn_start, pc_in, fetch_valid, fetch_data, insn_done, pc_next,
    input  z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_pc_rdata, z80fi_pc_wdata,
    input  err_overflow, err_protocol
  );

  // Collector side
  modport slave (
    input  insn_start, pc_in, fetch_valid, fetch_data, insn_done, pc_next,
    output z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_pc_rdata, z80fi_pc_wdata,
    output err_overflow, err_protocol
  );
endinterface

// File: rtl/z80fi_insn_collector.sv
// Z80FI instruction collector: packs the opcode bytes of one instruction
// (first byte in [7:0]) and emits a registered one-cycle retirement record.
// A byte fetched together with insn_done belongs to the retiring instruction;
// insn_start together with insn_done opens the next instruction on the same edge.
module z80fi_insn_collector #(
  parameter int MAX_LEN = 4
) (
  input logic                   clk,
  input logic                   reset,
  z80fi_insn_collector_if.slave bus
);
  localparam int W = 8 * MAX_LEN;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t         state_r, state_s;
  logic [2:0]     count_r, count_s;
  logic [W-1:0]   buf_r, buf_s;
  logic [15:0]    pc_start_r, pc_start_s;

  logic           valid_r, valid_s;
  logic [W-1:0]   insn_r, insn_s;
  logic [2:0]     len_r, len_s;
  logic [15:0]    rdata_r, rdata_s;
  logic [15:0]    wdata_r, wdata_s;
  logic           ovf_r, ovf_s;
  logic           proto_r, proto_s;

  // Buffer/count as they would look after merging this cycle's fetch into the open instruction
  logic [W-1:0]   fbuf_s;
  logic [2:0]     fcount_s;
  logic           fovf_s;

  // Merge a fetched byte at the current count, or flag overflow when the buffer is full
  always_comb begin
    fbuf_s   = buf_r;
    fcount_s = count_r;
    fovf_s   = 1'b0;
    if (bus.fetch_valid) begin
      if (count_r >= 3'(MAX_LEN)) begin
        fovf_s = 1'b1;
      end else begin
        for (int i = 0; i < MAX_LEN; i++) begin
          fbuf_s[8*i +: 8] = (count_r == 3'(i)) ? bus.fetch_data : buf_r[8*i +: 8];
        end
        fcount_s = count_r + 3'd1;
      end
    end else begin
      fovf_s = 1'b0;
    end
  end

  // Next-state, record capture and sticky error logic
  always_comb begin
    state_s    = state_r;
    count_s    = count_r;
    buf_s      = buf_r;
    pc_start_s = pc_start_r;
    valid_s    = 1'b0;
    insn_s     = insn_r;
    len_s      = len_r;
    rdata_s    = rdata_r;
    wdata_s    = wdata_r;
    ovf_s      = ovf_r;
    proto_s    = proto_r;
    case (state_r)
      IDLE: begin
        if (bus.insn_start) begin
          state_s    = COLLECT;
          pc_start_s = bus.pc_in;
          buf_s      = {W{1'b0}};
          if (bus.fetch_valid) begin
            buf_s[7:0] = bus.fetch_data;
            count_s    = 3'd1;
          end else begin
            count_s    = 3'd0;
          end
        end else if (bus.fetch_valid || bus.insn_done) begin
          proto_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      COLLECT: begin
        if (bus.insn_done) begin
          valid_s = 1'b1;
          insn_s  = fbuf_s;
          len_s   = fcount_s;
          rdata_s = pc_start_r;
          wdata_s = bus.pc_next;
          ovf_s   = ovf_r | fovf_s;
          if (fcount_s == 3'd0) begin
            proto_s = 1'b1;
          end else begin
            proto_s = proto_r;
          end
          if (bus.insn_start) begin
            pc_start_s = bus.pc_in;
            buf_s      = {W{1'b0}};
            count_s    = 3'd0;
          end else begin
            state_s    = IDLE;
          end
        end else if (bus.insn_start) begin
          // Abandoned instruction: discard it and open the new one
          proto_s    = 1'b1;
          pc_start_s = bus.pc_in;
          buf_s      = {W{1'b0}};
          if (bus.fetch_valid) begin
            buf_s[7:0] = bus.fetch_data;
            count_s    = 3'd1;
          end else begin
            count_s    = 3'd0;
          end
        end else begin
          buf_s   = fbuf_s;
          count_s = fcount_s;
          ovf_s   = ovf_r | fovf_s;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered record outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      count_r    <= 3'd0;
      buf_r      <= {W{1'b0}};
      pc_start_r <= 16'h0000;
      valid_r    <= 1'b0;
      insn_r     <= {W{1'b0}};
      len_r      <= 3'd0;
      rdata_r    <= 16'h0000;
      wdata_r    <= 16'h0000;
      ovf_r      <= 1'b0;
      proto_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      buf_r      <= buf_s;
      pc_start_r <= pc_start_s;
      valid_r    <= valid_s;
      insn_r     <= insn_s;
      len_r      <= len_s;
      rdata_r    <= rdata_s;
      wdata_r    <= wdata_s;
      ovf_r      <= ovf_s;
      proto_r    <= proto_s;
    end
  end

  assign bus.z80fi_valid    = valid_r;
  assign bus.z80fi_insn     = insn_r;
  assign bus.z80fi_insn_len = len_r;
  assign bus.z80fi_pc_rdata = rdata_r;
  assign bus.z80fi_pc_wdata = wdata_r;
  assign bus.err_overflow   = ovf_r;
  assign bus.err_protocol   = proto_r;
endmodule

// File: tb/tb_z80fi_insn_collector.sv
// Scoreboard bench for z80fi_insn_collector: directed stimulus pushes expected
// records; a forked monitor pops and compares on every z80fi_valid pulse.
module tb_z80fi_insn_collector;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  z80fi_insn_collector_if #(.MAX_LEN(4)) bus ();

  z80fi_insn_collector #(.MAX_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] insn;
    logic [2:0]  len;
    logic [15:0] rd;
    logic [15:0] wd;
  } rec_t;

  rec_t exp_q[$];
  int n_checks    = 0;
  int n_fails     = 0;
  int n_pulses    = 0;
  int exp_pulses  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_rec(input logic [31:0] insn, input logic [2:0] len,
                            input logic [15:0] rd, input logic [15:0] wd);
    rec_t r;
    r.insn = insn;
    r.len  = len;
    r.rd   = rd;
    r.wd   = wd;
    exp_q.push_back(r);
    exp_pulses++;
  endtask

  task automatic monitor();
    rec_t e;
    forever begin
      @(negedge clk);
      if (bus.z80fi_valid === 1'b1) begin
        n_pulses++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_pulse: got valid=1 insn=%h, expected no record", bus.z80fi_insn);
        end else begin
          e = exp_q.pop_front();
          chk("rec_insn", bus.z80fi_insn, e.insn);
          chk("rec_len", 32'(bus.z80fi_insn_len), 32'(e.len));
          chk("rec_pc_rdata", 32'(bus.z80fi_pc_rdata), 32'(e.rd));
          chk("rec_pc_wdata", 32'(bus.z80fi_pc_wdata), 32'(e.wd));
        end
      end
    end
  endtask

  // One clock of stimulus; inputs return to idle just after the edge
  task automatic cyc(input logic st, input logic [15:0] pc, input logic fv,
                     input logic [7:0] fd, input logic dn, input logic [15:0] pcn);
    bus.insn_start  = st;
    bus.pc_in       = pc;
    bus.fetch_valid = fv;
    bus.fetch_data  = fd;
    bus.insn_done   = dn;
    bus.pc_next     = pcn;
    @(posedge clk);
    #1;
    bus.insn_start  = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.insn_done   = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] b);
    cyc(1'b0, 16'h0000, 1'b1, b, 1'b0, 16'h0000);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.z80fi_valid), 32'd0);
    chk({tag, "_insn"}, bus.z80fi_insn, 32'd0);
    chk({tag, "_len"}, 32'(bus.z80fi_insn_len), 32'd0);
    chk({tag, "_pc_rdata"}, 32'(bus.z80fi_pc_rdata), 32'd0);
    chk({tag, "_pc_wdata"}, 32'(bus.z80fi_pc_wdata), 32'd0);
    chk({tag, "_err_overflow"}, 32'(bus.err_overflow), 32'd0);
    chk({tag, "_err_protocol"}, 32'(bus.err_protocol), 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.insn_start  = 1'b0;
    bus.pc_in       = 16'h0000;
    bus.fetch_valid = 1'b0;
    bus.fetch_data  = 8'h00;
    bus.insn_done   = 1'b0;
    bus.pc_next     = 16'h0000;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // 1: single-byte instruction, then valid drops
    cyc(1'b1, 16'h0100, 1'b0, 8'h00, 1'b0, 16'h0000);
    fetch(8'h78);
    expect_rec(32'h00000078, 3'd1, 16'h0100, 16'h0101);
    cyc(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h0101);
    @(posedge clk);
    #1;
    chk("t1_valid_drops", 32'(bus.z80fi_valid), 32'd0);
    chk("t1_insn_holds", bus.z80fi_insn, 32'h00000078);

    // 2: four-byte DD CB 05 46
    cyc(1'b1, 16'h1000, 1'b0, 8'h00, 1'b0, 16'h0000);
    fetch(8'hDD); fetch(8'hCB); fetch(8'h05); fetch(8'h46);
    expect_rec(32'h4605CBDD, 3'd4, 16'h1000, 16'h1004);
    cyc(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h1004);
    chk("t2_err_overflow", 32'(bus.err_overflow), 32'd0);
    chk("t2_err_protocol", 32'(bus.err_protocol), 32'd0);

    // 2b: fetch coincident with start and with done
    cyc(1'b1, 16'h2000, 1'b1, 8'hED, 1'b0, 16'h0000);
    expect_rec(32'h0000B0ED, 3'd2, 16'h2000, 16'h2002);
    cyc(1'b0, 16'h0000, 1'b1, 8'hB0, 1'b1, 16'h2002);

    // 3: overflow, fifth byte dropped
    cyc(1'b1, 16'h3000, 1'b0, 8'h00, 1'b0, 16'h0000);
    fetch(8'hDD); fetch(8'hCB); fetch(8'h05); fetch(8'h46); fetch(8'hFF);
    expect_rec(32'h4605CBDD, 3'd4, 16'h3000, 16'h3004);
    cyc(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h3004);
    chk("t3_err_overflow", 32'(bus.err_overflow), 32'd1);
    chk("t3_err_protocol", 32'(bus.err_protocol), 32'd0);

    // 4: done+start on the same edge
    cyc(1'b1, 16'h0200, 1'b1, 8'h00, 1'b0, 16'h0000);
    expect_rec(32'h00000000, 3'd1, 16'h0200, 16'h0201);
    cyc(1'b1, 16'h0201, 1'b0, 8'h00, 1'b1, 16'h0201);
    fetch(8'hED); fetch(8'h57);
    expect_rec(32'h000057ED, 3'd2, 16'h0201, 16'h0203);
    cyc(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h0203);

    // 4b: back-to-back pulses on consecutive cycles
    cyc(1'b1, 16'h0300, 1'b1, 8'h3E, 1'b0, 16'h0000);
    expect_rec(32'h0000423E, 3'd2, 16'h0300, 16'h0302);
    cyc(1'b1, 16'h0302, 1'b1, 8'h42, 1'b1, 16'h0302);
    expect_rec(32'h00000076, 3'd1, 16'h0302, 16'h0303);
    cyc(1'b0, 16'h0000, 1'b1, 8'h76, 1'b1, 16'h0303);
    chk("t4_b2b_second_valid", 32'(bus.z80fi_valid), 32'd1);
    chk("t4_err_overflow_sticky", 32'(bus.err_overflow), 32'd1);
    chk("t4_err_protocol", 32'(bus.err_protocol), 32'd0);

    // 5: fetch in IDLE flags a protocol error, which stays set
    @(posedge clk);
    #1;
    fetch(8'h12);
    chk("t5_err_protocol", 32'(bus.err_protocol), 32'd1);
    cyc(1'b1, 16'h0500, 1'b1, 8'h00, 1'b0, 16'h0000);
    expect_rec(32'h00000000, 3'd1, 16'h0500, 16'h0501);
    cyc(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h0501);
    chk("t5_err_protocol_sticky", 32'(bus.err_protocol), 32'd1);

    // 6: reset mid-instruction drops it and clears everything
    cyc(1'b1, 16'h0600, 1'b0, 8'h00, 1'b0, 16'h0000);
    fetch(8'h11); fetch(8'h22);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("t6_reset");
    reset = 1'b0;

    // Zero-length retire: record with len 0 plus protocol error
    cyc(1'b1, 16'h0700, 1'b0, 8'h00, 1'b0, 16'h0000);
    expect_rec(32'h00000000, 3'd0, 16'h0700, 16'h0700);
    cyc(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h0700);
    chk("zlen_err_protocol", 32'(bus.err_protocol), 32'd1);
    chk("zlen_err_overflow", 32'(bus.err_overflow), 32'd0);

    // insn_done in IDLE: no record, protocol error
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h0800);
    chk("idle_done_err_protocol", 32'(bus.err_protocol), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("pulse_count", 32'(n_pulses), 32'(exp_pulses));
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
